posit_ldd_frontend: RTL and testbench
=====================================

Name: posit_ldd_frontend

Overview:
- Pipelined front end of the posit decoder. It sits directly upstream of the LDD shifter.
- Accepts a raw n-bit posit through a valid/ready handshake and extracts the sign.
- Two's-complements negative inputs and flags zero and NaR.
- Produces the one-hot leading-digit-detect vector and the all-same flag that the shifter needs to resolve regime, exponent and fraction.

Parameters:
- n, 16, posit width
- es, 1, exponent width; passed through for consistency with the shifter, no logic depends on it
- ls, n-2, width of the ldd vector

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  posit_in holds a valid word
- in_ready  output  1  block can accept a word this cycle
- posit_in  input  n  raw posit
- out_valid  output  1  outputs hold a valid decoded word
- out_ready  input  1  downstream accepts the word this cycle
- sign  output  1  posit_in[n-1] of the word
- is_zero  output  1  word was all zeros
- is_nar  output  1  word was 1 followed by n-1 zeros
- body  output  n-1  magnitude bits: (sign ? -posit_in : posit_in)[n-2:0]
- ldd  output  ls  one-hot regime-terminator position
- allone  output  1  all n-1 body bits equal; no terminator exists

Behaviour:
- Handshake:
  - Transfer in on in_valid && in_ready.
  - Transfer out on out_valid && out_ready.
  - Outputs are held stable while out_valid && !out_ready.
- Two registered stages, S1 and S2. Latency is 2 cycles from input transfer to out_valid with no stall.
- Each stage has a valid bit. A stage loads when it is empty or its contents move on in the same cycle:
  - s2_load = !s2_v || out_ready
  - s1_load = !s1_v || (s2_load)
  - in_ready = s1_load
- Full throughput is one word per cycle. A bubble in S2 is filled while out is stalled.
- S1 registers:
  - sign = posit_in[n-1]
  - body = two's complement of posit_in when sign=1, truncated to n-1 bits, else posit_in[n-2:0]
  - is_zero = (posit_in == 0)
  - is_nar = (posit_in == 1 followed by zeros)
- S2 registers the S1 fields plus ldd and allone, both computed from S1 body:
  - ldd[j]=1 for the highest j in [0, ls-1] with body[j] != body[n-2], and every body bit between j and n-2 exclusive equal to body[n-2]. All other bits of ldd are 0.
  - ldd is at most one-hot. The regime run length m gives terminator index j = n-2-m.
  - allone = 1 iff no such j exists (body all ones or all zeros), and then ldd = 0.
- Zero and NaR:
  - Both produce body = 0, so allone = 1.
  - Flags pass through unchanged; the downstream consumer gives is_zero/is_nar priority.
- No arithmetic overflow exists. Negating 0x8000 (n=16) yields 0x8000; is_nar covers it.
- Reset (rst_n=0 at a clock edge):
  - s1_v=0, s2_v=0, out_valid=0, in_ready=1 from the next cycle.
  - All data outputs go to 0 (sign, is_zero, is_nar, body, ldd, allone).
  - A word in flight is discarded. A reset asserted while out is stalled still drops it.
- In-flight and held words are unaffected by posit_in/in_valid changes when in_ready=0.
- Data registers load only on a stage load with a valid source. Invalid cycles do not disturb held outputs.

Test Plan:
1. Reset, then send 0x4000 with out_ready=1.
   -> out_valid 2 cycles later with sign=0, body=0x4000, ldd=14'h2000, allone=0, is_zero=0, is_nar=0.
2. Send 0xC000, 0x2000, 0x0001 back-to-back with out_ready=1.
   -> three consecutive out_valid cycles:
   - 0xC000: sign=1, body=0x4000, ldd=14'h2000
   - 0x2000: sign=0, body=0x2000, ldd=14'h2000
   - 0x0001: sign=0, body=0x0001, ldd=14'h0001
3. Send 0x7FFF, 0x0000, 0x8000.
   -> 0x7FFF: allone=1, ldd=0.
   -> 0x0000: is_zero=1, allone=1, body=0.
   -> 0x8000: is_nar=1, sign=1, body=0, allone=1.
4. Backpressure: stream 0x4000, 0x4800, 0x5000, 0x5800 and hold out_ready=0 for 4 cycles.
   -> in_ready drops after 2 words are accepted.
   -> outputs stay at the 0x4000 result while stalled.
   -> on release, all four words emerge in order with no loss or duplication.
5. Reset mid-stream: assert rst_n=0 for 1 cycle while S1 and S2 are full and stalled.
   -> out_valid=0 and outputs 0 the next cycle, in_ready=1.
   -> the next accepted word appears alone after 2 cycles.
6. Random 1000 words with random in_valid/out_ready.
   -> every output matches a reference model (body, one-hot ldd, allone, flags), in order, with the count of words out equal to the count of words in.

Source files
------------

// File: rtl/posit_ldd_frontend_if.sv
// Handshake bundle for the posit LDD front end: raw posit in, decoded fields out.
// The master side drives the words in and the out_ready backpressure; the slave side is the decoder.
interface posit_ldd_frontend_if #(
  parameter int n  = 16,
  parameter int ls = n - 2
);
  logic          in_valid;
  logic          in_ready;
  logic [n-1:0]  posit_in;

  logic          out_valid;
  logic          out_ready;
  logic          sign;
  logic          is_zero;
  logic          is_nar;
  logic [n-2:0]  body;
  logic [ls-1:0] ldd;
  logic          allone;

  modport master (
    output in_valid, posit_in, out_ready,
    input  in_ready, out_valid, sign, is_zero, is_nar, body, ldd, allone
  );

  modport slave (
    input  in_valid, posit_in, out_ready,
    output in_ready, out_valid, sign, is_zero, is_nar, body, ldd, allone
  );
endinterface

// File: rtl/posit_ldd_frontend.sv
// Two-stage posit decoder front end: S1 takes sign/magnitude/special flags,
// S2 adds the one-hot regime-terminator vector consumed by the LDD shifter.
module posit_ldd_frontend #(
  parameter int n  = 16,
  parameter int es = 1,
  parameter int ls = n - 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  posit_ldd_frontend_if.slave  bus
);

  localparam logic [n-1:0] nar_word = {1'b1, {(n-1){1'b0}}};

  if (es < 0 || es > n - 3 || ls != n - 2) begin : g_param_check
    $error("posit_ldd_frontend: inconsistent n/es/ls parameters");
  end

  logic          r_s1_v;
  logic          r_s1_sign;
  logic          r_s1_zero;
  logic          r_s1_nar;
  logic [n-2:0]  r_s1_body;

  logic          r_s2_v;
  logic          r_s2_sign;
  logic          r_s2_zero;
  logic          r_s2_nar;
  logic [n-2:0]  r_s2_body;
  logic [ls-1:0] r_s2_ldd;
  logic          r_s2_allone;

  logic          w_s2_load;
  logic          w_s1_load;
  logic [n-1:0]  w_neg;
  logic [n-2:0]  w_body;
  logic [ls-1:0] w_ldd;
  logic          w_found;

  // A stage may load when empty or when its current word leaves this cycle.
  assign w_s2_load = !r_s2_v || bus.out_ready;
  assign w_s1_load = !r_s1_v || w_s2_load;

  // Negating the NaR pattern wraps back to itself; is_nar marks that case.
  assign w_neg  = -bus.posit_in;
  assign w_body = bus.posit_in[n-1] ? w_neg[n-2:0] : bus.posit_in[n-2:0];

  // NOTE: combinational blocks assign every output a default first so no path leaves one unassigned and infers a latch.
  always_comb begin
    w_ldd   = '0;
    w_found = 1'b0;
    for (int j = ls - 1; j >= 0; j--) begin
      if (!w_found && (r_s1_body[j] != r_s1_body[n-2])) begin
        w_ldd[j] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  // NOTE: data registers are reset as well as valids, so a reset clears the visible outputs to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_v      <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_zero   <= 1'b0;
      r_s1_nar    <= 1'b0;
      r_s1_body   <= '0;
      r_s2_v      <= 1'b0;
      r_s2_sign   <= 1'b0;
      r_s2_zero   <= 1'b0;
      r_s2_nar    <= 1'b0;
      r_s2_body   <= '0;
      r_s2_ldd    <= '0;
      r_s2_allone <= 1'b0;
    end else begin
      if (w_s1_load) begin
        r_s1_v <= bus.in_valid;
        if (bus.in_valid) begin
          r_s1_sign <= bus.posit_in[n-1];
          r_s1_zero <= (bus.posit_in == '0);
          r_s1_nar  <= (bus.posit_in == nar_word);
          r_s1_body <= w_body;
        end
      end

      if (w_s2_load) begin
        r_s2_v <= r_s1_v;
        if (r_s1_v) begin
          r_s2_sign   <= r_s1_sign;
          r_s2_zero   <= r_s1_zero;
          r_s2_nar    <= r_s1_nar;
          r_s2_body   <= r_s1_body;
          r_s2_ldd    <= w_ldd;
          r_s2_allone <= !w_found;
        end
      end
    end
  end

  assign bus.in_ready  = w_s1_load;
  assign bus.out_valid = r_s2_v;
  assign bus.sign      = r_s2_sign;
  assign bus.is_zero   = r_s2_zero;
  assign bus.is_nar    = r_s2_nar;
  assign bus.body      = r_s2_body;
  assign bus.ldd       = r_s2_ldd;
  assign bus.allone    = r_s2_allone;

endmodule

// File: tb/tb_posit_ldd_frontend.sv
// Directed and randomized checks of posit_ldd_frontend at n=16, es=1.
module tb_posit_ldd_frontend;

  typedef struct packed {
    logic        sign;
    logic        is_zero;
    logic        is_nar;
    logic [14:0] body;
    logic [13:0] ldd;
    logic        allone;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec  = 0;
  int   n_miss = 0;

  posit_ldd_frontend_if #(.n(16)) bus ();

  posit_ldd_frontend #(.n(16), .es(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic res_t get_obs();
    res_t r;
    r = {bus.sign, bus.is_zero, bus.is_nar, bus.body, bus.ldd, bus.allone};
    return r;
  endfunction

  function automatic res_t mk(input logic s, input logic z, input logic na,
                              input logic [14:0] b, input logic [13:0] l, input logic a);
    res_t r;
    r = {s, z, na, b, l, a};
    return r;
  endfunction

  task automatic check_out(input string tag, input res_t exp);
    check({tag, " out_valid"}, bus.out_valid, 1'b1);
    check(tag, get_obs(), exp);
  endtask

  // Reference: measure the regime run length m from the top body bit; terminator sits at 14-m.
  function automatic res_t model(input logic [15:0] p);
    res_t        r;
    logic [15:0] mag;
    int          m;
    mag       = p[15] ? (16'd0 - p) : p;
    r         = '0;
    r.sign    = p[15];
    r.is_zero = (p == 16'h0000);
    r.is_nar  = (p == 16'h8000);
    r.body    = mag[14:0];
    m = 1;
    while (m < 15 && r.body[14-m] == r.body[14]) m++;
    if (m == 15) r.allone = 1'b1;
    else         r.ldd    = 14'd1 << (14 - m);
    return r;
  endfunction

  function automatic logic [15:0] rand_posit();
    case ($urandom_range(0, 9))
      0:       return 16'h0000;
      1:       return 16'h8000;
      2:       return 16'h7FFF;
      3:       return 16'hFFFF;
      4:       return 16'h0001;
      default: return 16'($urandom());
    endcase
  endfunction

  initial begin
    res_t exp_q[$];
    res_t held;
    logic was_stalled;
    int   n_in, n_out, cycles;

    // Reset state
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.posit_in  = 16'h0000;
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("rst out_valid", bus.out_valid, 1'b0);
    check("rst in_ready", bus.in_ready, 1'b1);
    check("rst data", get_obs(), res_t'(0));
    rst_n = 1'b1;

    // 1: single word, two-cycle latency
    bus.posit_in = 16'h4000; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("t1 not yet valid", bus.out_valid, 1'b0);
    tick();
    check_out("t1 4000", mk(0, 0, 0, 15'h4000, 14'h2000, 0));
    tick();
    check("t1 drained", bus.out_valid, 1'b0);

    // 2: back-to-back words
    bus.posit_in = 16'hC000; bus.in_valid = 1'b1;
    tick();
    bus.posit_in = 16'h2000;
    tick();
    check_out("t2 C000", mk(1, 0, 0, 15'h4000, 14'h2000, 0));
    bus.posit_in = 16'h0001;
    tick();
    check_out("t2 2000", mk(0, 0, 0, 15'h2000, 14'h2000, 0));
    bus.in_valid = 1'b0;
    tick();
    check_out("t2 0001", mk(0, 0, 0, 15'h0001, 14'h0001, 0));
    tick();
    check("t2 drained", bus.out_valid, 1'b0);

    // 3: all-ones, zero, NaR
    bus.posit_in = 16'h7FFF; bus.in_valid = 1'b1;
    tick();
    bus.posit_in = 16'h0000;
    tick();
    check_out("t3 7FFF", mk(0, 0, 0, 15'h7FFF, 14'h0000, 1));
    bus.posit_in = 16'h8000;
    tick();
    check_out("t3 0000", mk(0, 1, 0, 15'h0000, 14'h0000, 1));
    bus.in_valid = 1'b0;
    tick();
    check_out("t3 8000", mk(1, 0, 1, 15'h0000, 14'h0000, 1));
    tick();
    check("t3 drained", bus.out_valid, 1'b0);

    // 4: backpressure
    bus.out_ready = 1'b0;
    bus.posit_in  = 16'h4000; bus.in_valid = 1'b1;
    #1;
    check("t4 ready empty", bus.in_ready, 1'b1);
    tick();
    bus.posit_in = 16'h4800;
    #1;
    check("t4 ready s2 empty", bus.in_ready, 1'b1);
    tick();
    bus.posit_in = 16'h5000;
    #1;
    check("t4 ready full", bus.in_ready, 1'b0);
    check_out("t4 stall 4000", mk(0, 0, 0, 15'h4000, 14'h2000, 0));
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4 ready held low", bus.in_ready, 1'b0);
      check_out("t4 stall hold", mk(0, 0, 0, 15'h4000, 14'h2000, 0));
    end
    bus.out_ready = 1'b1;
    #1;
    check("t4 ready release", bus.in_ready, 1'b1);
    tick();
    check_out("t4 4800", mk(0, 0, 0, 15'h4800, 14'h2000, 0));
    bus.posit_in = 16'h5800;
    tick();
    check_out("t4 5000", mk(0, 0, 0, 15'h5000, 14'h2000, 0));
    bus.in_valid = 1'b0;
    tick();
    check_out("t4 5800", mk(0, 0, 0, 15'h5800, 14'h2000, 0));
    tick();
    check("t4 drained", bus.out_valid, 1'b0);

    // 5: reset while both stages full and stalled
    bus.out_ready = 1'b0;
    bus.posit_in  = 16'h2000; bus.in_valid = 1'b1;
    tick();
    bus.posit_in = 16'h1000;
    tick();
    bus.in_valid = 1'b0;
    #1;
    check("t5 full stalled", bus.in_ready, 1'b0);
    rst_n = 1'b0;
    tick();
    check("t5 rst out_valid", bus.out_valid, 1'b0);
    check("t5 rst data", get_obs(), res_t'(0));
    check("t5 rst in_ready", bus.in_ready, 1'b1);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    bus.posit_in  = 16'h0800; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("t5 old words gone", bus.out_valid, 1'b0);
    tick();
    check_out("t5 0800", mk(0, 0, 0, 15'h0800, 14'h0800, 0));
    tick();
    check("t5 alone", bus.out_valid, 1'b0);

    // 6: random traffic against the reference model
    n_in = 0; n_out = 0; cycles = 0;
    was_stalled = 1'b0; held = '0;
    while ((n_in < 1000 || exp_q.size() != 0) && cycles < 20000) begin
      bus.in_valid  = (n_in < 1000) && ($urandom_range(0, 3) != 0);
      bus.posit_in  = rand_posit();
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (was_stalled) begin
        check("t6 stall valid", bus.out_valid, 1'b1);
        check("t6 stall stable", get_obs(), held);
      end
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (exp_q.size() != 0) check("t6 word", get_obs(), exp_q.pop_front());
      end
      was_stalled = bus.out_valid && !bus.out_ready;
      held        = get_obs();
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.posit_in));
        n_in++;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    bus.in_valid = 1'b0;
    check("t6 words in", n_in, 1000);
    check("t6 count out", n_out, n_in);
    check("t6 drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
